// File: rtl/fetch_decode_buffer_pkg.sv
// Shared types and defaults for the fetch-to-decode instruction buffer.
package fetch_decode_buffer_pkg;

    localparam int          DEFAULT_DEPTH = 4;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

    // Instruction and its PC+4 travel as one word so they can never skew.
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the instruction buffer.
interface fetch_decode_buffer_if #(
    parameter int DEPTH = fetch_decode_buffer_pkg::DEFAULT_DEPTH
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [31:0]   in_instruction;
    logic [31:0]   in_pc4;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_instruction;
    logic [31:0]   out_pc4;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_instruction, in_pc4, out_ready, flush,
        output in_ready, out_valid, out_instruction, out_pc4, count
    );

    modport master (
        output in_valid, in_instruction, in_pc4, out_ready, flush,
        input  in_ready, out_valid, out_instruction, out_pc4, count
    );
endinterface

// File: rtl/fetch_entry_ram.sv
// DEPTH x 64-bit entry storage: synchronous write, asynchronous read.
module fetch_entry_ram
    import fetch_decode_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  fetch_entry_t  wr_data,
    input  logic [AW-1:0] rd_addr,
    output fetch_entry_t  rd_data
);
    // Contents are never reset; the reader masks stale words with its valid flag.
    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fetch_decode_buffer.sv
// Small FIFO between fetch and decode with flush; the head is read combinationally from storage.
module fetch_decode_buffer #(
    parameter int          DEPTH    = fetch_decode_buffer_pkg::DEFAULT_DEPTH,
    parameter logic [31:0] NOP_WORD = fetch_decode_buffer_pkg::NOP_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_decode_buffer_if.slave  bus
);
    import fetch_decode_buffer_pkg::*;

    localparam int             PW         = $clog2(DEPTH);
    localparam int             CW         = PW + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          ready_reg;
    logic          head_valid;
    logic          push;
    logic          pop;
    fetch_entry_t  wr_entry;
    fetch_entry_t  rd_entry;

    assign head_valid = (count_reg != '0);
    assign push       = bus.in_valid && ready_reg && !bus.flush;
    assign pop        = head_valid && bus.out_ready && !bus.flush;

    always_comb begin
        count_next = count_reg;
        if (bus.flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    // in_ready is registered from next-state count, so it is 0 in reset and
    // never depends combinationally on out_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            ready_reg <= (count_next != FULL_COUNT);
            if (bus.flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    assign wr_entry = '{instruction: bus.in_instruction, pc4: bus.in_pc4};

    fetch_entry_ram #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_entry)
    );

    assign bus.in_ready        = ready_reg;
    assign bus.out_valid       = head_valid;
    assign bus.out_instruction = head_valid ? rd_entry.instruction : NOP_WORD;
    assign bus.out_pc4         = head_valid ? rd_entry.pc4 : 32'h0;
    assign bus.count           = count_reg;
endmodule
